// File: rtl/tour_cmd_sequencer.sv
// Command sequencer feeding remoteComm: buffers 16-bit Knight commands, issues them one at a time and checks each ack.
// Optional macro SEQ_RETRY_EN: a failed command (bad response or timeout) is re-issued once before erroring.
module tour_cmd_sequencer #(
    parameter int         DEPTH   = 16,
    parameter int         TIMEOUT = 8000000,
    parameter logic [7:0] ACK     = 8'hA5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_wr,
    input  logic [15:0]                load_data,
    input  logic                       start,
    input  logic                       abort,
    output logic [15:0]                cmd,
    output logic                       send_cmd,
    input  logic                       cmd_sent,
    input  logic                       resp_rdy,
    input  logic [7:0]                 resp,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [1:0]                 err_code,
    output logic [$clog2(DEPTH+1)-1:0] num_done,
    output logic                       full,
    output logic                       empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int TW = ($clog2(TIMEOUT+1) > 24) ? $clog2(TIMEOUT+1) : 24;
    localparam logic [TW-1:0] TMAX = '1;
    localparam logic [TW-1:0] TLIM = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_SENT, WAIT_RESP, FIN, ERR} state_t;
    state_t state, state_nx;

    logic [15:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [TW-1:0] timer;
    logic [15:0]   head;
    logic          do_start, do_send, do_pop, do_push, do_ack, do_flush;
    logic          fail, to_err, overflow, timed_out;
    logic [1:0]    fail_code;

    assign head      = mem[rd_ptr];
    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign busy      = (state == ISSUE) || (state == WAIT_SENT) || (state == WAIT_RESP);
    assign done      = (state == FIN);
    assign timed_out = (timer >= TLIM);
    assign overflow  = load_wr && (busy || full);
    assign do_push   = load_wr && !busy && !full && !do_flush;

`ifdef SEQ_RETRY_EN
    logic [15:0] hold_cmd;
    logic        retried, retry_pend;
    assign do_pop = do_send && !retry_pend;
`else
    assign do_pop = do_send;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        do_start  = 1'b0;
        do_send   = 1'b0;
        do_ack    = 1'b0;
        fail      = 1'b0;
        fail_code = 2'b00;
        to_err    = 1'b0;
        do_flush  = 1'b0;
        case (state)
            IDLE: if (start && !empty) begin
                state_nx = ISSUE;
                do_start = 1'b1;
            end
            ISSUE: begin
                do_send  = 1'b1;
                state_nx = WAIT_SENT;
            end
            WAIT_SENT: begin
                if (timed_out) begin
                    fail      = 1'b1;
                    fail_code = 2'b10;
                end else if (cmd_sent) begin
                    state_nx = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                // A response arriving on the timeout cycle takes precedence.
                if (resp_rdy) begin
                    if (resp == ACK) begin
                        do_ack   = 1'b1;
                        state_nx = empty ? FIN : ISSUE;
                    end else begin
                        fail      = 1'b1;
                        fail_code = 2'b01;
                    end
                end else if (timed_out) begin
                    fail      = 1'b1;
                    fail_code = 2'b10;
                end
            end
            FIN:     state_nx = IDLE;
            ERR:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (fail) begin
`ifdef SEQ_RETRY_EN
            if (!retried) state_nx = ISSUE;
            else          to_err   = 1'b1;
`else
            to_err = 1'b1;
`endif
        end
        if (to_err) begin
            state_nx = ERR;
            do_flush = 1'b1;
        end
        // abort overrides everything, including a same-cycle ack or failure
        if (abort) begin
            state_nx = IDLE;
            do_flush = 1'b1;
            do_start = 1'b0;
            do_send  = 1'b0;
            do_ack   = 1'b0;
            fail     = 1'b0;
            to_err   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= load_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            timer    <= '0;
            cmd      <= '0;
            send_cmd <= 1'b0;
            err      <= 1'b0;
            err_code <= 2'b00;
            num_done <= '0;
        end else begin
            send_cmd <= do_send;
            if (do_send) begin
`ifdef SEQ_RETRY_EN
                cmd <= retry_pend ? hold_cmd : head;
`else
                cmd <= head;
`endif
                timer <= '0;
            end else if ((state == WAIT_SENT || state == WAIT_RESP) && timer != TMAX) begin
                timer <= timer + TW'(1);
            end

            if (do_flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + PW'(1);
                if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
                if (do_push && !do_pop)      count <= count + CW'(1);
                else if (do_pop && !do_push) count <= count - CW'(1);
            end

            if (do_start) begin
                err      <= 1'b0;
                err_code <= 2'b00;
                num_done <= '0;
            end
            if (do_ack) num_done <= num_done + CW'(1);
            if (to_err) begin
                err      <= 1'b1;
                err_code <= fail_code;
            end
            if (overflow) begin
                err      <= 1'b1;
                err_code <= 2'b11;
            end
        end
    end

`ifdef SEQ_RETRY_EN
    always_ff @(posedge clk) begin
        if (do_pop) hold_cmd <= head;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retried    <= 1'b0;
            retry_pend <= 1'b0;
        end else if (do_flush || do_start) begin
            retried    <= 1'b0;
            retry_pend <= 1'b0;
        end else begin
            if (do_pop)       retried    <= 1'b0;
            else if (do_send) retry_pend <= 1'b0;
            if (fail && !retried) begin
                retried    <= 1'b1;
                retry_pend <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_tour_cmd_sequencer.sv
// Bench for tour_cmd_sequencer: directed scenarios plus randomized sequences scored against a queue-based model.
// Expectations follow SEQ_RETRY_EN when that macro is defined for the build.
module tb_tour_cmd_sequencer;
    localparam int         DEPTH   = 16;
    localparam int         TIMEOUT = 100;
    localparam logic [7:0] ACK     = 8'hA5;
    localparam int         NW      = $clog2(DEPTH+1);
`ifdef SEQ_RETRY_EN
    localparam bit RETRY = 1'b1;
`else
    localparam bit RETRY = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_wr = 1'b0;
    logic [15:0]   load_data = '0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [15:0]   cmd;
    logic          send_cmd;
    logic          cmd_sent = 1'b0;
    logic          resp_rdy = 1'b0;
    logic [7:0]    resp = '0;
    logic          busy, done, err, full, empty;
    logic [1:0]    err_code;
    logic [NW-1:0] num_done;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int send_cnt = 0;

    tour_cmd_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .ACK(ACK)) dut (
        .clk(clk), .rst(rst), .load_wr(load_wr), .load_data(load_data),
        .start(start), .abort(abort), .cmd(cmd), .send_cmd(send_cmd),
        .cmd_sent(cmd_sent), .resp_rdy(resp_rdy), .resp(resp), .busy(busy),
        .done(done), .err(err), .err_code(err_code), .num_done(num_done),
        .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done === 1'b1)     done_cnt <= done_cnt + 1;
        if (send_cmd === 1'b1) send_cnt <= send_cnt + 1;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic load_cmd(input logic [15:0] d);
        load_wr = 1'b1;
        load_data = d;
        tick();
        load_wr = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic ack_cycle(input logic [7:0] r);
        cmd_sent = 1'b1;
        tick();
        cmd_sent = 1'b0;
        resp_rdy = 1'b1;
        resp = r;
        tick();
        resp_rdy = 1'b0;
    endtask

    task automatic wait_send(output bit ok, output logic [15:0] c);
        ok = 1'b0;
        c = '0;
        for (int i = 0; i < 300 && !ok; i++) begin
            tick();
            if (send_cmd === 1'b1) begin
                ok = 1'b1;
                c = cmd;
            end
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            if (busy === 1'b0) ok = 1'b1;
            else tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        checks++; if ({cmd, send_cmd} !== 17'h0) begin errors++; $display("FAIL reset_cmd: got cmd=%h send=%b want 0000/0", cmd, send_cmd); end
        checks++; if ({busy, done, err} !== 3'b000) begin errors++; $display("FAIL reset_flags: got busy/done/err=%b%b%b want 000", busy, done, err); end
        checks++; if ({err_code, num_done} !== '0) begin errors++; $display("FAIL reset_counts: got code=%b num_done=%0d want 0/0", err_code, num_done); end
        checks++; if ({empty, full} !== 2'b10) begin errors++; $display("FAIL reset_buf: got empty/full=%b%b want 10", empty, full); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        load_cmd(16'h2000);
        load_cmd(16'h43F2);
        pulse_start();
        checks++; if ({busy, send_cmd} !== 2'b10) begin errors++; $display("FAIL basic_issue: got busy/send=%b%b want 10", busy, send_cmd); end
        tick();
        checks++; if ({send_cmd, cmd} !== {1'b1, 16'h2000}) begin errors++; $display("FAIL basic_send1: got send=%b cmd=%h want 1/2000", send_cmd, cmd); end
        ack_cycle(ACK);
        checks++; if (send_cmd !== 1'b0) begin errors++; $display("FAIL basic_gap: got send=%b want 0", send_cmd); end
        tick();
        checks++; if ({send_cmd, cmd} !== {1'b1, 16'h43F2}) begin errors++; $display("FAIL basic_send2: got send=%b cmd=%h want 1/43f2", send_cmd, cmd); end
        ack_cycle(ACK);
        checks++; if ({done, busy, num_done} !== {1'b1, 1'b0, NW'(2)}) begin errors++; $display("FAIL basic_done: got done=%b busy=%b num_done=%0d want 1/0/2", done, busy, num_done); end
        tick();
        checks++; if ({done, empty, err, cmd} !== {1'b0, 1'b1, 1'b0, 16'h43F2}) begin errors++; $display("FAIL basic_after: got done=%b empty=%b err=%b cmd=%h want 0/1/0/43f2", done, empty, err, cmd); end
    endtask

    task automatic test_bad_resp();
        load_cmd(16'h2000);
        pulse_start();
        tick();
        ack_cycle(8'h5A);
        if (RETRY) begin
            tick();
            checks++; if ({send_cmd, cmd} !== {1'b1, 16'h2000}) begin errors++; $display("FAIL bad_retry: got send=%b cmd=%h want 1/2000", send_cmd, cmd); end
            ack_cycle(8'h5A);
        end
        checks++; if ({err, err_code, busy, empty} !== {1'b1, 2'b01, 1'b0, 1'b1}) begin errors++; $display("FAIL bad_resp: got err=%b code=%b busy=%b empty=%b want 1/01/0/1", err, err_code, busy, empty); end
    endtask

    task automatic test_timeout();
        int k;
        int want;
        load_cmd(16'h43F2);
        pulse_start();
        tick();
        k = 0;
        want = RETRY ? (2 * TIMEOUT + 1) : TIMEOUT;
        while (err !== 1'b1 && k < 400) begin
            tick();
            k++;
        end
        checks++; if (k !== want) begin errors++; $display("FAIL timeout_cycles: got %0d want %0d", k, want); end
        checks++; if ({err_code, busy} !== {2'b10, 1'b0}) begin errors++; $display("FAIL timeout_code: got code=%b busy=%b want 10/0", err_code, busy); end
    endtask

    task automatic test_resp_wins();
        load_cmd(16'h1234);
        pulse_start();
        tick();
        cmd_sent = 1'b1;
        tick();
        cmd_sent = 1'b0;
        repeat (TIMEOUT - 2) tick();
        resp_rdy = 1'b1;
        resp = ACK;
        tick();
        resp_rdy = 1'b0;
        checks++; if ({done, err, num_done} !== {1'b1, 1'b0, NW'(1)}) begin errors++; $display("FAIL resp_wins: got done=%b err=%b num_done=%0d want 1/0/1", done, err, num_done); end
        tick();
    endtask

    task automatic test_overflow();
        logic [15:0] vals[DEPTH];
        bit ok;
        logic [15:0] c;
        int ok_cnt;
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            vals[i] = 16'($urandom);
            load_cmd(vals[i]);
        end
        checks++; if ({full, empty, err} !== 3'b100) begin errors++; $display("FAIL ovf_full: got full/empty/err=%b%b%b want 100", full, empty, err); end
        load_cmd(16'hDEAD);
        checks++; if ({err, err_code, full} !== {1'b1, 2'b11, 1'b1}) begin errors++; $display("FAIL ovf_err: got err=%b code=%b full=%b want 1/11/1", err, err_code, full); end
        pulse_start();
        ok_cnt = 0;
        for (int i = 0; i < DEPTH; i++) begin
            wait_send(ok, c);
            if (ok && c === vals[i]) ok_cnt++;
            ack_cycle(ACK);
        end
        checks++; if (ok_cnt !== DEPTH) begin errors++; $display("FAIL ovf_contents: got %0d matching sends want %0d", ok_cnt, DEPTH); end
        checks++; if ({done, num_done, err} !== {1'b1, NW'(DEPTH), 1'b0}) begin errors++; $display("FAIL ovf_drain: got done=%b num_done=%0d err=%b want 1/%0d/0", done, num_done, err, DEPTH); end
        tick();
    endtask

    task automatic test_abort();
        bit ok;
        logic [15:0] c;
        int d0;
        int s0;
        load_cmd(16'hA001);
        load_cmd(16'hA002);
        load_cmd(16'hA003);
        pulse_start();
        d0 = done_cnt;
        wait_send(ok, c);
        ack_cycle(ACK);
        wait_send(ok, c);
        checks++; if ({ok, c} !== {1'b1, 16'hA002}) begin errors++; $display("FAIL abort_send2: got ok=%b cmd=%h want 1/a002", ok, c); end
        cmd_sent = 1'b1;
        tick();
        cmd_sent = 1'b0;
        load_cmd(16'hBEEF);
        checks++; if ({err, err_code, busy} !== {1'b1, 2'b11, 1'b1}) begin errors++; $display("FAIL abort_busy_load: got err=%b code=%b busy=%b want 1/11/1", err, err_code, busy); end
        abort = 1'b1;
        resp_rdy = 1'b1;
        resp = ACK;
        tick();
        abort = 1'b0;
        resp_rdy = 1'b0;
        s0 = send_cnt;
        checks++; if ({busy, empty, send_cmd, num_done, err} !== {1'b0, 1'b1, 1'b0, NW'(1), 1'b1}) begin errors++; $display("FAIL abort_state: got busy=%b empty=%b send=%b num_done=%0d err=%b want 0/1/0/1/1", busy, empty, send_cmd, num_done, err); end
        repeat (5) tick();
        checks++; if ({done_cnt - d0, send_cnt - s0} !== {32'd0, 32'd0}) begin errors++; $display("FAIL abort_quiet: got done pulses=%0d sends=%0d want 0/0", done_cnt - d0, send_cnt - s0); end
    endtask

    task automatic test_async_reset();
        bit ok;
        logic [15:0] c;
        load_cmd(16'h1111);
        load_cmd(16'h2222);
        pulse_start();
        wait_send(ok, c);
        ack_cycle(ACK);
        wait_send(ok, c);
        cmd_sent = 1'b1;
        tick();
        cmd_sent = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++; if ({cmd, num_done, busy, empty, send_cmd} !== {16'h0, NW'(0), 1'b0, 1'b1, 1'b0}) begin errors++; $display("FAIL async_reset: got cmd=%h num_done=%0d busy=%b empty=%b send=%b want 0000/0/0/1/0", cmd, num_done, busy, empty, send_cmd); end
        tick();
        rst = 1'b0;
        resp_rdy = 1'b1;
        resp = ACK;
        tick();
        resp_rdy = 1'b0;
        tick();
        checks++; if ({num_done, busy, done} !== {NW'(0), 1'b0, 1'b0}) begin errors++; $display("FAIL post_reset_resp: got num_done=%0d busy=%b done=%b want 0/0/0", num_done, busy, done); end
    endtask

    task automatic test_random();
        logic [15:0] q[$];
        logic [15:0] c;
        logic [7:0]  r;
        logic [1:0]  exp_code;
        bit ok, fin, failed_once;
        int n, exp_done, d0, outcome;
        for (int it = 0; it < 20; it++) begin
            q.delete();
            n = $urandom_range(1, DEPTH);
            for (int i = 0; i < n; i++) begin
                c = 16'($urandom);
                q.push_back(c);
                load_cmd(c);
            end
            d0 = done_cnt;
            exp_done = 0;
            exp_code = 2'b00;
            failed_once = 1'b0;
            fin = 1'b0;
            pulse_start();
            while (!fin) begin
                wait_send(ok, c);
                checks++; if (!ok || c !== q[0]) begin errors++; $display("FAIL rand_send it%0d: got ok=%b cmd=%h want 1/%h", it, ok, c, q[0]); end
                if (!ok) begin
                    fin = 1'b1;
                    exp_code = 2'bxx;
                end else begin
                    outcome = $urandom_range(0, 9);
                    if ($urandom_range(0, 3) == 0) begin
                        resp_rdy = 1'b1;
                        resp = 8'h00;
                        tick();
                        resp_rdy = 1'b0;
                    end
                    repeat ($urandom_range(0, 3)) tick();
                    cmd_sent = 1'b1;
                    tick();
                    cmd_sent = 1'b0;
                    if (outcome < 9) begin
                        repeat ($urandom_range(0, 3)) tick();
                        r = 8'($urandom);
                        if (r == ACK) r = 8'h5A;
                        resp_rdy = 1'b1;
                        resp = (outcome < 7) ? ACK : r;
                        tick();
                        resp_rdy = 1'b0;
                    end
                    if (outcome < 7) begin
                        exp_done++;
                        void'(q.pop_front());
                        failed_once = 1'b0;
                        if (q.size() == 0) fin = 1'b1;
                    end else if (RETRY && !failed_once) begin
                        failed_once = 1'b1;
                    end else begin
                        fin = 1'b1;
                        exp_code = (outcome < 9) ? 2'b01 : 2'b10;
                    end
                end
            end
            wait_idle(ok);
            repeat (2) tick();
            checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rand_idle it%0d: got busy=%b want 0", it, busy); end
            checks++; if (num_done !== NW'(exp_done)) begin errors++; $display("FAIL rand_num_done it%0d: got %0d want %0d", it, num_done, exp_done); end
            checks++; if ({err, err_code} !== {exp_code != 2'b00, exp_code}) begin errors++; $display("FAIL rand_err it%0d: got err=%b code=%b want code %b", it, err, err_code, exp_code); end
            checks++; if ((done_cnt - d0) !== ((exp_code == 2'b00) ? 1 : 0) || empty !== 1'b1) begin errors++; $display("FAIL rand_done it%0d: got done pulses=%0d empty=%b want %0d/1", it, done_cnt - d0, empty, (exp_code == 2'b00) ? 1 : 0); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_resp();
        test_timeout();
        test_resp_wins();
        test_overflow();
        test_abort();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
